// File: rtl/mult4_rr_sched_pkg.sv
// Shared types and widths for the round-robin Mult4 / Mult4_TT3 scheduler.
package mult4_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } slot_state_t;

  localparam int PROD_W = 8;
  localparam int OPND_W = 4;
  localparam int ID_W   = 3;

endpackage

// File: rtl/mult4_rr_sched_cells.sv
// Multiplier cells: exact 4x4 product and an approximate product that drops
// every partial-product bit landing in the three least-significant columns.
module Mult4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module Mult4_TT3 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i + j >= 3) begin
          p = p + ({7'b0000000, a[i] & b[j]} << (i + j));
        end
      end
    end
  end
endmodule

// File: rtl/mult4_rr_sched_rr_arb.sv
// Rotating-priority arbiter: first asserted request at or above ptr wins,
// otherwise the lowest asserted request overall (wrap-around).
module rr_arb
  import mult4_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  logic [NUM_REQ-1:0] hi_req;

  always_comb begin
    hi_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_req[i] = req[i] && (ID_W'(i) >= ptr);
    end
  end

  // Descending scans leave the lowest matching index as the winner.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (|hi_req) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (hi_req[i]) begin
          gnt     = '0;
          gnt[i]  = 1'b1;
          gnt_idx = ID_W'(i);
        end
      end
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt     = '0;
          gnt[i]  = 1'b1;
          gnt_idx = ID_W'(i);
        end
      end
    end
    if (!en) gnt = '0;
  end

endmodule

// File: rtl/mult4_rr_sched.sv
// Shares one exact and one approximate 4x4 multiplier among NUM_REQ requesters
// with round-robin grant, a single response slot and a saturating error sum.
module mult4_rr_sched
  import mult4_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ACC_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [4*NUM_REQ-1:0]  req_a,
  input  logic [4*NUM_REQ-1:0]  req_b,
  input  logic [NUM_REQ-1:0]    req_approx,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_product,
  output logic [7:0]            rsp_exact,
  output logic [7:0]            rsp_err,
  output logic [2:0]            rsp_id,
  output logic                  rsp_mode,
  input  logic                  acc_clr,
  output logic [ACC_W-1:0]      err_acc
);

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [PROD_W-1:0] inc);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, inc};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

  slot_state_t         state_q, state_d;
  logic [ID_W-1:0]     ptr_q;
  logic                slot_free;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [OPND_W-1:0]   a_p0, b_p0;
  logic                mode_p0;
  logic [PROD_W-1:0]   exact_p0, approx_p0, err_p0;

  logic [PROD_W-1:0]   prod_p1, exact_p1, err_p1;
  logic [ID_W-1:0]     id_p1;
  logic                mode_p1;
  logic                vld_p1;
  logic [ACC_W-1:0]    acc_q;

  assign slot_free = (state_q == IDLE) | rsp_ready;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (slot_free & ~rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign gnt_any   = |gnt;

  // Stage p0: operand select and both products for the granted requester.
  always_comb begin
    a_p0    = '0;
    b_p0    = '0;
    mode_p0 = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_p0    = req_a[OPND_W*i +: OPND_W];
        b_p0    = req_b[OPND_W*i +: OPND_W];
        mode_p0 = req_approx[i];
      end
    end
  end

  Mult4     u_exact  (.a(a_p0), .b(b_p0), .p(exact_p0));
  Mult4_TT3 u_approx (.a(a_p0), .b(b_p0), .p(approx_p0));

  assign err_p0 = (exact_p0 >= approx_p0) ? (exact_p0 - approx_p0)
                                          : (approx_p0 - exact_p0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (gnt_any) state_d = FULL;
      FULL: if (rsp_ready && !gnt_any) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_any) begin
        ptr_q <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
    end
  end

  // Stage p1: response slot, loaded whenever a request transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_p1  <= '0;
      exact_p1 <= '0;
      err_p1   <= '0;
      id_p1    <= '0;
      mode_p1  <= 1'b0;
    end else if (gnt_any) begin
      prod_p1  <= mode_p0 ? approx_p0 : exact_p0;
      exact_p1 <= exact_p0;
      err_p1   <= err_p0;
      id_p1    <= gnt_idx;
      mode_p1  <= mode_p0;
    end
  end

  assign vld_p1 = (state_q == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (vld_p1 && rsp_ready && mode_p1) begin
      acc_q <= sat_add(acc_q, err_p1);
    end
  end

  assign rsp_valid   = vld_p1;
  assign rsp_product = prod_p1;
  assign rsp_exact   = exact_p1;
  assign rsp_err     = err_p1;
  assign rsp_id      = id_p1;
  assign rsp_mode    = mode_p1;
  assign err_acc     = acc_q;

endmodule
